// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//   8N1 UART transmitter with an internal byte FIFO. Core logic pushes bytes,
//   the block serialises them LSB first at BIT_RATE onto the TxD pin. Frames
//   queued back to back go out with no idle gap between them.
//
// Parameters
//   CLOCK_FREQ   system clock frequency in Hz
//   BIT_RATE     serial bit rate; CLOCK_FREQ/BIT_RATE clocks per bit (>= 2)
//   BUFFER_SIZE  FIFO depth in bytes (power of two, >= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   wr_en     in   push wr_data into the FIFO this cycle
//   wr_data   in   byte to transmit (ignored when wr_en is low)
//   full      out  FIFO holds BUFFER_SIZE bytes
//   empty     out  FIFO holds no bytes
//   count     out  bytes queued, excluding the byte currently on the wire
//   overflow  out  sticky: a write arrived while full
//   clr_ovf   in   clears overflow; wins over a same-cycle set
//   busy      out  a frame (start..stop) is on the wire
//   tx        out  serial line, idle high, registered
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
   parameter int CLOCK_FREQ  = 100000000,
   parameter int BIT_RATE    = 115200,
   parameter int BUFFER_SIZE = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [7:0]                   wr_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(BUFFER_SIZE):0] count,
   output logic                         overflow,
   input  logic                         clr_ovf,
   output logic                         busy,
   output logic                         tx
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
   localparam int AW           = $clog2(BUFFER_SIZE);
   localparam int CW           = AW + 1;
   localparam int BW           = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH     = CW'(BUFFER_SIZE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   // FIFO state
   logic [7:0]    mem_q [BUFFER_SIZE];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          overflow_q, overflow_d;

   // Serialiser state
   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;

   logic          push;
   logic          pop;
   logic          baud_last;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      // Acceptance uses registered full: a write while full is dropped even
      // if the serialiser frees a slot in the same cycle.
      push       = wr_en && !full_q;
      pop        = 1'b0;
      baud_last  = (baud_q == BAUD_LAST);

      state_d    = state_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;

      case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next frame when more data is queued.
               if (!empty_q) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Pop only happens when non-empty and push only when not full, so the
      // count never under/overflows and the pointers wrap naturally.
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      full_d     = (count_d == DEPTH);
      empty_d    = (count_d == '0);
      overflow_d = clr_ovf ? 1'b0 : (overflow_q || (wr_en && full_q));

      // tx and busy are computed from the current state and registered, so
      // the pin changes one cycle after the state and is glitch free.
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_q != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values from before the edge regardless of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   // NOTE: the byte storage has no reset; a slot is only read after it has
   // been written, which the count guarantees, so its power-up value is moot.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Directed bench for uart_tx_buffered with CLKS_PER_BIT = 4 and a 4-byte
//   FIFO. Stimulus pushes each byte it expects on the wire into a queue; an
//   independent monitor decodes frames from tx at bit centres and compares
//   them with the queue head. Flag, count and timing checks are made inline.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

   localparam int CLOCK_FREQ  = 400;
   localparam int BIT_RATE    = 100;
   localparam int BUFFER_SIZE = 4;
   localparam int CPB         = 4;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       overflow;
   logic       clr_ovf;
   logic       busy;
   logic       tx;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   uart_tx_buffered #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .BIT_RATE   (BIT_RATE),
      .BUFFER_SIZE(BUFFER_SIZE)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .overflow(overflow),
      .clr_ovf (clr_ovf),
      .busy    (busy),
      .tx      (tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one write for one cycle; returns at the following falling edge.
   task automatic push_one(input logic [7:0] b, input bit accept);
      wr_en   = 1'b1;
      wr_data = b;
      if (accept) exp_q.push_back(b);
      @(negedge clk);
   endtask

   task automatic idle_in();
      wr_en   = 1'b0;
      wr_data = 8'h00;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   // Frame monitor: start detected at sample 0, start checked at sample 2,
   // data bit k at sample 6+4k, stop at sample 38. Reset aborts the frame.
   initial begin : monitor
      logic [7:0] rx;
      logic       start_v;
      logic       stop_v;
      bit         abort;
      forever begin
         @(negedge clk);
         if (reset && tx == 1'b0) begin
            abort   = 1'b0;
            rx      = 8'h00;
            start_v = 1'b1;
            stop_v  = 1'b0;
            for (int s = 1; s <= 38; s++) begin
               @(negedge clk);
               if (!reset) begin
                  abort = 1'b1;
                  break;
               end
               if (s == 2) start_v = tx;
               if (s >= 6 && s <= 34 && ((s - 6) % 4) == 0) rx = {tx, rx[7:1]};
               if (s == 38) stop_v = tx;
            end
            if (!abort) begin
               check("start_bit", {31'd0, start_v}, 32'd0);
               check("stop_bit", {31'd0, stop_v}, 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame_unexpected: got 0x%02h, expected no frame", rx);
               end else begin
                  check("frame_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      bit gap;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      clr_ovf = 1'b0;
      reset   = 1'b1;

      // 1: asynchronous reset, observed before any clock edge
      #2 reset = 1'b0;
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 2: single byte latency and busy timing
      push_one(8'hA5, 1'b1);                       // edge N
      idle_in();
      check("t2_tx_n0", {31'd0, tx}, 32'd1);
      check("t2_count_n0", {29'd0, count}, 32'd1);
      @(negedge clk);                              // N+1.5
      check("t2_tx_n1", {31'd0, tx}, 32'd1);
      check("t2_busy_n1", {31'd0, busy}, 32'd0);
      check("t2_empty_n1", {31'd0, empty}, 32'd1);
      @(negedge clk);                              // N+2.5
      check("t2_tx_n2", {31'd0, tx}, 32'd0);
      check("t2_busy_n2", {31'd0, busy}, 32'd1);
      repeat (39) @(negedge clk);                  // N+41.5
      check("t2_busy_n41", {31'd0, busy}, 32'd1);
      @(negedge clk);                              // N+42.5
      check("t2_busy_n42", {31'd0, busy}, 32'd0);
      check("t2_tx_n42", {31'd0, tx}, 32'd1);
      wait_idle(100, "t2_drain");

      // 3: three back-to-back frames
      push_one(8'h00, 1'b1);                       // edge N
      push_one(8'hFF, 1'b1);
      push_one(8'h55, 1'b1);                       // now at N+2.5
      idle_in();
      check("t3_count_n2", {29'd0, count}, 32'd2);
      gap = 1'b0;
      for (int t = 3; t <= 122; t++) begin
         @(negedge clk);
         if (t == 40) check("t3_count_n40", {29'd0, count}, 32'd2);
         if (t == 41) check("t3_count_n41", {29'd0, count}, 32'd1);
         if (t == 81) begin
            check("t3_count_n81", {29'd0, count}, 32'd0);
            check("t3_empty_n81", {31'd0, empty}, 32'd1);
         end
         if (t <= 121 && !busy) gap = 1'b1;
         if (t == 122) check("t3_busy_end", {31'd0, busy}, 32'd0);
      end
      check("t3_no_gap", {31'd0, gap}, 32'd0);
      wait_idle(100, "t3_drain");

      // 4: fill while busy, overflow, clear with priority over a set
      push_one(8'h11, 1'b1);                       // edge M
      idle_in();
      repeat (3) @(negedge clk);
      push_one(8'h12, 1'b1);
      push_one(8'h13, 1'b1);
      push_one(8'h14, 1'b1);
      check("t4_full_3", {31'd0, full}, 32'd0);
      push_one(8'h15, 1'b1);
      check("t4_full_4", {31'd0, full}, 32'd1);
      check("t4_count_4", {29'd0, count}, 32'd4);
      check("t4_ovf_4", {31'd0, overflow}, 32'd0);
      push_one(8'h16, 1'b0);
      check("t4_ovf_5", {31'd0, overflow}, 32'd1);
      check("t4_count_5", {29'd0, count}, 32'd4);
      clr_ovf = 1'b1;
      push_one(8'h77, 1'b0);                       // dropped write, clear wins
      clr_ovf = 1'b0;
      idle_in();
      check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
      check("t4_count_clr", {29'd0, count}, 32'd4);
      wait_idle(260, "t4_drain");

      // 5: push on the pop cycle, and push while full on the pop cycle
      push_one(8'h21, 1'b1);                       // edge P, pop at P+1
      idle_in();
      @(negedge clk);
      push_one(8'h22, 1'b1);
      push_one(8'h23, 1'b1);                       // P+3.5
      idle_in();
      check("t5_count_a", {29'd0, count}, 32'd2);
      repeat (37) @(negedge clk);                  // P+40.5
      check("t5_count_b", {29'd0, count}, 32'd2);
      push_one(8'h24, 1'b1);                       // edge P+41 = pop
      idle_in();
      check("t5_count_pushpop", {29'd0, count}, 32'd2);
      push_one(8'h25, 1'b1);
      push_one(8'h26, 1'b1);                       // P+43.5
      idle_in();
      check("t5_full", {31'd0, full}, 32'd1);
      repeat (37) @(negedge clk);                  // P+80.5
      check("t5_count_c", {29'd0, count}, 32'd4);
      push_one(8'h27, 1'b0);                       // edge P+81 = pop, full
      idle_in();
      check("t5_ovf_popfull", {31'd0, overflow}, 32'd1);
      check("t5_count_popfull", {29'd0, count}, 32'd3);
      check("t5_full_popfull", {31'd0, full}, 32'd0);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      wait_idle(300, "t5_drain");

      // 6: reset during data bit 3 of 0x3C with two bytes queued
      push_one(8'h3C, 1'b0);                       // edge Q, pop at Q+1
      idle_in();
      @(negedge clk);
      push_one(8'hE1, 1'b0);
      push_one(8'hE2, 1'b0);                       // Q+3.5
      idle_in();
      check("t6_count_pre", {29'd0, count}, 32'd2);
      repeat (15) @(negedge clk);                  // Q+18.5, bit 3 on the wire
      check("t6_busy_pre", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t6_tx_rst", {31'd0, tx}, 32'd1);
      check("t6_count_rst", {29'd0, count}, 32'd0);
      check("t6_empty_rst", {31'd0, empty}, 32'd1);
      check("t6_busy_rst", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_tx_idle", {31'd0, tx}, 32'd1);
      check("t6_empty_idle", {31'd0, empty}, 32'd1);
      push_one(8'h81, 1'b1);
      idle_in();
      wait_idle(100, "t6_drain");
      check("t6_count_end", {29'd0, count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
